// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the digit counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide add/sub slice: ripple of per-bit cells, b inverted for subtract.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             op,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Ripple the carry through each bit; c_msb_in ends up as the carry into the top bit.
  always_comb begin
    logic c;
    logic bx;
    s        = '0;
    c_msb_in = 1'b0;
    c        = ci;
    bx       = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      bx       = b[i] ^ (op == OP_SUB);
      s[i]     = a[i] ^ bx ^ c;
      c_msb_in = c;
      c        = (a[i] & bx) | (a[i] & c) | (bx & c);
    end
    co = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor, LSB first, DIGIT bits per cycle.
// Optional feature: define ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ov,
  output logic             zf,
  output logic             nf
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

  // Operand width must split into whole digits.
  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_cfg
      $fatal(1, "addsub_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               op_q;
  logic               carry_q;
  logic               accept;
  logic               last;
  logic [DIGIT-1:0]   slice_s;
  logic               slice_co;
  logic               slice_cm;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   res_final;
  logic               ov_c;
`ifdef ADDSUB_SAT_EN
  logic               a_sign_q;
`endif

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .op       (op_q),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_cm)
  );

  // New digit enters the result register from the MSB side.
  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign res_next = slice_s;
    end else begin : g_multi_digit
      assign res_next = {slice_s, result[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign ov_c = slice_co ^ slice_cm;

  // Final value written on the last digit, clamped on overflow when saturation is built.
  always_comb begin
    res_final = res_next;
`ifdef ADDSUB_SAT_EN
    if (ov_c) begin
      res_final = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Next-state logic and accept/last decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand shifters, carry, counter, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      result   <= '0;
      co       <= 1'b0;
      ov       <= 1'b0;
      zf       <= 1'b0;
      nf       <= 1'b0;
`ifdef ADDSUB_SAT_EN
      a_sign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh     <= a;
        b_sh     <= b;
        op_q     <= op;
        carry_q  <= op;
        cnt_q    <= '0;
`ifdef ADDSUB_SAT_EN
        a_sign_q <= a[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
        a_sh    <= a_sh >> DIGIT;
        b_sh    <= b_sh >> DIGIT;
        carry_q <= slice_co;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last) begin
          result <= res_final;
          co     <= slice_co;
          ov     <= ov_c;
          zf     <= (res_final == '0);
          nf     <= res_final[WIDTH-1];
        end else begin
          result <= res_next;
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: DIGIT=1 and DIGIT=4 instances at WIDTH=8.
// Follows ADDSUB_SAT_EN the same way as the design.
module tb_addsub_serial;
  import addsub_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v, op_v, busy_v, done_v, co_v, ov_v, zf_v, nf_v;
  logic [7:0] a_v [2];
  logic [7:0] b_v [2];
  logic [7:0] res_v [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
    .co(co_v[0]), .ov(ov_v[0]), .zf(zf_v[0]), .nf(nf_v[0])
  );

  addsub_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
    .co(co_v[1]), .ov(ov_v[1]), .zf(zf_v[1]), .nf(nf_v[1])
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Reference: {result, co, ov, zf, nf} from integer arithmetic.
  function automatic logic [11:0] model(input logic op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ex;
    logic [7:0] r;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == OP_SUB) begin
      ex = sa - sb;
      r  = a - b;
      c  = (a >= b);
    end else begin
      ex = sa + sb;
      r  = a + b;
      c  = (int'(a) + int'(b)) > 255;
    end
    v = (ex > 127) || (ex < -128);
`ifdef ADDSUB_SAT_EN
    if (v) r = a[7] ? 8'h80 : 8'h7F;
`endif
    return {r, c, v, (r == 8'h00), r[7]};
  endfunction

  function automatic logic [11:0] obs(input int d);
    return {res_v[d], co_v[d], ov_v[d], zf_v[d], nf_v[d]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; lat counts cycles after the accept edge.
  task automatic run_op(input int d, input logic op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    start_v[d] = 1'b1;
    op_v[d]    = op;
    a_v[d]     = a;
    b_v[d]     = b;
    tick();
    start_v[d] = 1'b0;
    a_v[d]     = 8'($urandom);
    b_v[d]     = 8'($urandom);
    op_v[d]    = 1'($urandom);
    lat = 0;
    while (done_v[d] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_v[d], done_v[d], obs(d)} !== 14'h0) begin
        bad++;
        $display("FAIL reset d=%0d got=%h exp=%h", d, {busy_v[d], done_v[d], obs(d)}, 14'h0);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed(input int d);
    logic       ops [5];
    logic [7:0] as [5];
    logic [7:0] bs [5];
    logic [11:0] exp;
    int lat;
    ops = '{OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_ADD};
    as  = '{8'h7F, 8'h05, 8'h00, 8'h80, 8'h12};
    bs  = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h34};
    for (int i = 0; i < 5; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      run_op(d, ops[i], as[i], bs[i], lat);
      total++;
      if (lat != n_of(d)) begin
        bad++;
        $display("FAIL dir_latency d=%0d i=%0d got=%0d exp=%0d", d, i, lat, n_of(d));
      end
      total++;
      if (obs(d) !== exp) begin
        bad++;
        $display("FAIL dir_result d=%0d i=%0d got=%h exp=%h", d, i, obs(d), exp);
      end
      tick();
      total++;
      if ({busy_v[d], done_v[d]} !== 2'b00) begin
        bad++;
        $display("FAIL dir_done_pulse d=%0d i=%0d got=%b exp=00", d, i, {busy_v[d], done_v[d]});
      end
    end
  endtask

  task automatic test_busy_ignore(input int d);
    logic [11:0] exp;
    int lat;
    exp = model(OP_ADD, 8'h3C, 8'h0F);
    start_v[d] = 1'b1; op_v[d] = OP_ADD; a_v[d] = 8'h3C; b_v[d] = 8'h0F;
    tick();
    start_v[d] = 1'b1; op_v[d] = OP_SUB; a_v[d] = 8'hFF; b_v[d] = 8'h80;
    tick();
    lat = 1;
    start_v[d] = 1'b0;
    while (done_v[d] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat != n_of(d)) begin
      bad++;
      $display("FAIL busy_latency d=%0d got=%0d exp=%0d", d, lat, n_of(d));
    end
    total++;
    if (obs(d) !== exp) begin
      bad++;
      $display("FAIL busy_ignore d=%0d got=%h exp=%h", d, obs(d), exp);
    end
    tick();
  endtask

  task automatic test_reset_midrun(input int d);
    int lat, seen;
    run_op(d, OP_SUB, 8'h00, 8'h01, lat);
    tick();
    start_v[d] = 1'b1; op_v[d] = OP_ADD; a_v[d] = 8'h55; b_v[d] = 8'h66;
    tick();
    start_v[d] = 1'b0;
    tick();
    total++;
    if (busy_v[d] !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy d=%0d got=%b exp=1", d, busy_v[d]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_v[d], done_v[d], obs(d)} !== 14'h0) begin
      bad++;
      $display("FAIL mid_reset d=%0d got=%h exp=%h", d, {busy_v[d], done_v[d], obs(d)}, 14'h0);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < n_of(d) + 2; i++) begin
      tick();
      if (done_v[d] === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_no_done d=%0d got=%0d exp=0", d, seen);
    end
    run_op(d, OP_ADD, 8'h12, 8'h34, lat);
    total++;
    if (res_v[d] !== 8'h46 || lat != n_of(d)) begin
      bad++;
      $display("FAIL mid_after d=%0d got=%h/%0d exp=46/%0d", d, res_v[d], lat, n_of(d));
    end
    tick();
  endtask

  task automatic test_back_to_back(input int d);
    logic       op1, op2;
    logic [7:0] a1, b1, a2, b2;
    logic [11:0] exp;
    int lat, gap;
    op1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    op2 = 1'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    exp = model(op1, a1, b1);
    run_op(d, op1, a1, b1, lat);
    total++;
    if (obs(d) !== exp || lat != n_of(d)) begin
      bad++;
      $display("FAIL b2b_first d=%0d got=%h/%0d exp=%h/%0d", d, obs(d), lat, exp, n_of(d));
    end
    exp = model(op2, a2, b2);
    start_v[d] = 1'b1; op_v[d] = op2; a_v[d] = a2; b_v[d] = b2;
    tick();
    start_v[d] = 1'b0;
    total++;
    if (busy_v[d] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_idle d=%0d got=%b exp=1", d, busy_v[d]);
    end
    gap = 1;
    while (done_v[d] !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    total++;
    if (gap != n_of(d) + 1) begin
      bad++;
      $display("FAIL b2b_gap d=%0d got=%0d exp=%0d", d, gap, n_of(d) + 1);
    end
    total++;
    if (obs(d) !== exp) begin
      bad++;
      $display("FAIL b2b_second d=%0d got=%h exp=%h", d, obs(d), exp);
    end
    tick();
  endtask

  task automatic test_random(input int d);
    logic       op;
    logic [7:0] a, b;
    logic [11:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      if (i % 4 == 0) a = {1'($urandom), 7'h7F};
      exp = model(op, a, b);
      run_op(d, op, a, b, lat);
      total++;
      if (obs(d) !== exp || lat != n_of(d)) begin
        bad++;
        $display("FAIL rand d=%0d op=%b a=%h b=%h got=%h/%0d exp=%h/%0d",
                 d, op, a, b, obs(d), lat, exp, n_of(d));
      end
      if (i % 3 == 0) tick();
    end
    tick();
  endtask

  initial begin
    start_v = 2'b00;
    op_v    = 2'b00;
    a_v[0] = 8'h00; a_v[1] = 8'h00;
    b_v[0] = 8'h00; b_v[1] = 8'h00;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_directed(d);
      test_busy_ignore(d);
      test_reset_midrun(d);
      test_back_to_back(d);
      test_random(d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
